aes_key_sched_ctrl: RTL
=======================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
- REQ-001 Parameter: NR, default 10, AES-128 round count; round-key index range 0..NR; NR+1 keys total.
- REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
- REQ-003 rst_ni  in  1  reset, asynchronous assert, active-low.
- REQ-004 key_valid_i  in  1  new cipher key offered.
- REQ-005 key_i  in  128  cipher key; sampled on key handshake.
- REQ-006 key_ready_o  out  1  controller accepts a new key this cycle.
- REQ-007 exp_start_o  out  1  one-cycle start pulse to the expansion engine.
- REQ-008 exp_key_o  out  128  held key driven to the expansion engine.
- REQ-009 exp_done_i  in  NR+1  per-round-key done flags from the expansion engine.
- REQ-010 exp_rd_idx_o  out  4  round-key index presented to the engine read port.
- REQ-011 exp_rd_key_i  in  128  round key at exp_rd_idx_o, combinational from the engine.
- REQ-012 rk_req_i  in  1  cipher core requests a round key; held high until granted.
- REQ-013 rk_idx_i  in  4  requested round-key index; stable while rk_req_i is high.
- REQ-014 rk_gnt_o  out  1  one-cycle grant; rk_o is valid in the same cycle.
- REQ-015 rk_o  out  128  registered round key.
- REQ-016 rk_err_o  out  1  one-cycle pulse; index > NR, or request made in IDLE.
- REQ-017 busy_o  out  1  high in START and EXPAND.

Function
- REQ-018 FSM states: IDLE, START, EXPAND, READY.
- REQ-019 key_ready_o = 1 in IDLE and READY; 0 in START and EXPAND.
- REQ-020 Key handshake (key_valid_i & key_ready_o): key_i is latched into exp_key_o and the FSM moves to START.
- REQ-021 START lasts one cycle with exp_start_o = 1, then moves to EXPAND.
- REQ-022 EXPAND moves to READY in the cycle after exp_done_i[NR] is observed high.
- REQ-023 Requests are served in EXPAND and READY; exp_rd_idx_o = rk_idx_i.
- REQ-024 Serviceable request (idx <= NR and exp_done_i[idx] = 1): next cycle rk_o <= exp_rd_key_i and rk_gnt_o = 1.
- REQ-025 Not-yet-done index: stall with rk_gnt_o = 0 until the flag rises; no error.
- REQ-026 Grant latency is one cycle from first eligibility; at most one grant per two cycles, with no regrant in the grant cycle.
- REQ-027 Index > NR, or any request in IDLE: next cycle rk_err_o = 1, rk_gnt_o = 1, rk_o = 0.
- REQ-028 Key handshake in READY aborts service: any pending request is dropped without grant, and the FSM goes to START.
- REQ-029 Simultaneous key handshake and request: the key load wins and the request is not granted that cycle.
- REQ-030 In START, exp_done_i is ignored, and all requests stall.

Reset
- REQ-031 Reset assertion clears, immediately and asynchronously: state = IDLE, exp_key_o = 0, rk_o = 0, rk_gnt_o = 0, rk_err_o = 0, exp_start_o = 0.
- REQ-032 Reset mid-EXPAND discards the key; the first post-reset key restarts expansion from round 0.

Configuration
- REQ-033 Macro AES_KEY_CTRL_ZEROIZE_EN, when defined, adds input port zeroize_i (1 bit).
- REQ-034 With the macro, zeroize_i = 1 clears exp_key_o and rk_o next cycle, forces IDLE, and drops any pending request.
- REQ-035 With the macro, zeroize_i takes priority over a simultaneous key handshake.
- REQ-036 Without the macro, the port is absent, and key material persists until reset or reload.

Structure
- REQ-037 Shared package aes_pkg holds: the FSM state enum, AES_KEY_W = 128, AES128_NR = 10, and RK_IDX_W = 4.
- REQ-038 Optional sub-module aes_rk_req_port contains the request/grant/error register stage; everything else is flat.

Verification
- REQ-039 Key 2b7e151628aed2a6abf7158809cf4f3c, then request idx 10 after done -> rk_gnt_o with rk_o = d014f9a8c9ee2589e13f0cc8b6630ca6.
- REQ-040 Request idx 5 issued during EXPAND before exp_done_i[5] -> stall; grant exactly one cycle after the flag rises.
- REQ-041 Request idx 12 in READY -> next cycle rk_err_o = 1, rk_gnt_o = 1, rk_o = 0.
- REQ-042 key_valid_i and rk_req_i (idx 3) in the same READY cycle -> exp_start_o pulse, no grant, FSM in EXPAND.
- REQ-043 rst_ni low mid-EXPAND -> all outputs zero immediately; new key after release restarts cleanly.
- REQ-044 (ZEROIZE_EN build) zeroize_i in READY with a concurrent key -> rk_o = 0, exp_key_o = 0, state IDLE, no exp_start_o.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES-128 key-schedule controller.
package aes_pkg;

    localparam int AES_KEY_W = 128;
    localparam int AES128_NR = 10;
    localparam int RK_IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_EXPAND = 2'd2,
        ST_READY  = 2'd3
    } key_state_e;

endpackage

// File: rtl/aes_rk_req_port.sv
// Round-key request port output stage: registers grant, error and the served key.
module aes_rk_req_port
    import aes_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_grant,
    input  logic                 i_error,
    input  logic [AES_KEY_W-1:0] i_rd_key,
    output logic                 o_gnt,
    output logic                 o_err,
    output logic [AES_KEY_W-1:0] o_rk
);

    logic                 r_gnt;
    logic                 r_err;
    logic [AES_KEY_W-1:0] r_rk;

    // Grant/error pulses and the key register; an error serves an all-zero key.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt <= 1'b0;
            r_err <= 1'b0;
            r_rk  <= {AES_KEY_W{1'b0}};
        end else if (i_clear) begin
            r_gnt <= 1'b0;
            r_err <= 1'b0;
            r_rk  <= {AES_KEY_W{1'b0}};
        end else begin
            r_gnt <= i_grant | i_error;
            r_err <= i_error;
            if (i_error) begin
                r_rk <= {AES_KEY_W{1'b0}};
            end else if (i_grant) begin
                r_rk <= i_rd_key;
            end else begin
                r_rk <= r_rk;
            end
        end
    end

    assign o_gnt = r_gnt;
    assign o_err = r_err;
    assign o_rk  = r_rk;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: key handshake, expansion sequencing and round-key serving.
// Optional build macro AES_KEY_CTRL_ZEROIZE_EN adds zeroize_i to wipe key material.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 key_valid_i,
    input  logic [AES_KEY_W-1:0] key_i,
    output logic                 key_ready_o,
    output logic                 exp_start_o,
    output logic [AES_KEY_W-1:0] exp_key_o,
    input  logic [NR:0]          exp_done_i,
    output logic [RK_IDX_W-1:0]  exp_rd_idx_o,
    input  logic [AES_KEY_W-1:0] exp_rd_key_i,
`ifdef AES_KEY_CTRL_ZEROIZE_EN
    input  logic                 zeroize_i,
`endif
    input  logic                 rk_req_i,
    input  logic [RK_IDX_W-1:0]  rk_idx_i,
    output logic                 rk_gnt_o,
    output logic [AES_KEY_W-1:0] rk_o,
    output logic                 rk_err_o,
    output logic                 busy_o
);

    localparam int                IDX_SPAN = 1 << RK_IDX_W;
    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);

    key_state_e           r_state;
    key_state_e           w_state_nxt;
    logic [AES_KEY_W-1:0] r_exp_key;
    logic                 r_exp_start;
    logic [IDX_SPAN-1:0]  w_done_ext;
    logic                 w_zeroize;
    logic                 w_handshake;
    logic                 w_serving;
    logic                 w_idx_ok;
    logic                 w_accept;
    logic                 w_grant;
    logic                 w_error;
    logic                 w_gnt;

`ifdef AES_KEY_CTRL_ZEROIZE_EN
    assign w_zeroize = zeroize_i;
`else
    assign w_zeroize = 1'b0;
`endif

    assign key_ready_o  = (r_state == ST_IDLE) || (r_state == ST_READY);
    assign busy_o       = (r_state == ST_START) || (r_state == ST_EXPAND);
    assign exp_start_o  = r_exp_start;
    assign exp_key_o    = r_exp_key;
    assign exp_rd_idx_o = rk_idx_i;

    // Indices above NR read a zero-padded flag, so they never look serviceable.
    assign w_done_ext  = IDX_SPAN'(exp_done_i);
    assign w_handshake = key_valid_i & key_ready_o;
    assign w_serving   = (r_state == ST_EXPAND) || (r_state == ST_READY);
    assign w_idx_ok    = (rk_idx_i <= LAST_IDX);
    // A key load or zeroize wins over a request; nothing is regranted in the grant cycle.
    assign w_accept    = rk_req_i & ~w_handshake & ~w_zeroize & ~w_gnt;
    assign w_grant     = w_accept & w_serving & w_idx_ok & w_done_ext[rk_idx_i];
    assign w_error     = w_accept & ((w_serving & ~w_idx_ok) | (r_state == ST_IDLE));

    // Next-state selection for the key sequencing FSM.
    always_comb begin
        w_state_nxt = r_state;
        if (w_zeroize) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = w_handshake ? ST_START : ST_IDLE;
                ST_START:  w_state_nxt = ST_EXPAND;
                ST_EXPAND: w_state_nxt = exp_done_i[NR] ? ST_READY : ST_EXPAND;
                ST_READY:  w_state_nxt = w_handshake ? ST_START : ST_READY;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, held cipher key and the one-cycle expansion start pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_exp_key   <= {AES_KEY_W{1'b0}};
            r_exp_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_start <= w_handshake & ~w_zeroize;
            if (w_zeroize) begin
                r_exp_key <= {AES_KEY_W{1'b0}};
            end else if (w_handshake) begin
                r_exp_key <= key_i;
            end else begin
                r_exp_key <= r_exp_key;
            end
        end
    end

    aes_rk_req_port u_req_port (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_clear  (w_zeroize),
        .i_grant  (w_grant),
        .i_error  (w_error),
        .i_rd_key (exp_rd_key_i),
        .o_gnt    (w_gnt),
        .o_err    (rk_err_o),
        .o_rk     (rk_o)
    );

    assign rk_gnt_o = w_gnt;

endmodule
